barrel_shifter_pipe: RTL and testbench

- Parametrised, optionally pipelined barrel shifter with valid/ready handshake.
- Supports logical left, logical right, arithmetic right and rotate left.
- Produces a lost-bit flag for overflow detection or rounding sticky.
- Serves as the general shift/normalise datapath element for the AWGN datapath. Replaces fixed-width, left-only, purely combinational shifting.

---
 rtl/barrel_shifter_pipe.sv | 165 ++++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shifter_pipe
// Brief    : Parametrised log-depth barrel shifter (LSL/LSR/ASR/ROL) with
//            valid/ready handshake and a lost-bit (overflow/sticky) flag.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shifter_pipe #(
    parameter int WIDTH     = 48,
    parameter int SHW       = $clog2(WIDTH),
    parameter int PIPELINED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_flag
);

    localparam logic [1:0]   c_mode_lsl = 2'b00;
    localparam logic [1:0]   c_mode_lsr = 2'b01;
    localparam logic [1:0]   c_mode_asr = 2'b10;
    localparam logic [1:0]   c_mode_rol = 2'b11;
    localparam logic [SHW:0] c_width    = (SHW + 1)'(WIDTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [1:0]       mode;
        logic [SHW-1:0]   shift;
        logic             sign;
        logic [WIDTH-1:0] mask;   // positions holding sign copies (ASR only)
        logic             flag;
    } stage_t;

    stage_t w_lvl_in  [SHW];
    stage_t w_lvl_out [SHW];
    stage_t w_entry;

    logic             w_stall;
    logic [SHW:0]     w_shift_ext;
    logic [SHW:0]     w_shift_red;
    logic [SHW-1:0]   w_shift_eff;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_flag;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;

    // Rotation by WIDTH is the identity, so fold the amount into [0, WIDTH).
    assign w_shift_ext = {1'b0, in_shift};
    assign w_shift_red = w_shift_ext - c_width;
    assign w_shift_eff = ((in_mode == c_mode_rol) && (w_shift_ext >= c_width))
                         ? w_shift_red[SHW-1:0] : in_shift;

    always_comb begin
        w_entry       = '0;
        w_entry.valid = in_valid && in_ready;
        w_entry.data  = in_data;
        w_entry.mode  = in_mode;
        w_entry.shift = w_shift_eff;
        w_entry.sign  = in_data[WIDTH-1];
        w_entry.flag  = 1'b0;
        if (in_mode == c_mode_asr) begin
            w_entry.mask = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    assign w_lvl_in[0] = w_entry;

    // Level i handles shift bit K = SHW-1-i, i.e. a constant shift of 2^K.
    for (genvar i = 0; i < SHW; i++) begin : g_level
        localparam int K   = SHW - 1 - i;
        localparam int AMT = 1 << K;
        localparam logic [WIDTH-1:0] c_lo_mask = {WIDTH{1'b1}} >> (WIDTH - AMT);
        localparam logic [WIDTH-1:0] c_hi_mask = {WIDTH{1'b1}} << (WIDTH - AMT);

        stage_t w_cur;
        stage_t w_nxt;

        assign w_cur = w_lvl_in[i];

        always_comb begin
            w_nxt = w_cur;
            if (w_cur.shift[K]) begin
                w_nxt.shift[K] = 1'b0;
                case (w_cur.mode)
                    c_mode_lsl: begin
                        w_nxt.data = w_cur.data << AMT;
                        w_nxt.flag = w_cur.flag | (|(w_cur.data & c_hi_mask));
                    end
                    c_mode_lsr: begin
                        w_nxt.data = w_cur.data >> AMT;
                        w_nxt.flag = w_cur.flag | (|(w_cur.data & c_lo_mask));
                    end
                    c_mode_asr: begin
                        w_nxt.data = (w_cur.data >> AMT)
                                   | ({WIDTH{w_cur.sign}} & c_hi_mask);
                        w_nxt.mask = (w_cur.mask >> AMT)
                                   | ({WIDTH{w_cur.mask[WIDTH-1]}} & c_hi_mask);
                        // Sign copies are fill, not lost precision.
                        w_nxt.flag = w_cur.flag
                                   | (|(w_cur.data & ~w_cur.mask & c_lo_mask));
                    end
                    default: begin
                        w_nxt.data = (w_cur.data << AMT)
                                   | (w_cur.data >> (WIDTH - AMT));
                    end
                endcase
            end
        end

        assign w_lvl_out[i] = w_nxt;
    end

    for (genvar i = 0; i < SHW - 1; i++) begin : g_link
        if (PIPELINED != 0) begin : g_reg
            stage_t r_stage;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stage <= '0;
                end else if (!w_stall) begin
                    r_stage <= w_lvl_out[i];
                end
            end

            assign w_lvl_in[i+1] = r_stage;
        end else begin : g_comb
            assign w_lvl_in[i+1] = w_lvl_out[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_flag  <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= w_lvl_out[SHW-1].valid;
            r_out_data  <= w_lvl_out[SHW-1].data;
            r_out_flag  <= w_lvl_out[SHW-1].flag;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_flag  = r_out_flag;

    // Sideband fields of the final level are intentionally dropped.
    logic w_unused;
    assign w_unused = ^{w_lvl_out[SHW-1].mode, w_lvl_out[SHW-1].shift,
                        w_lvl_out[SHW-1].sign, w_lvl_out[SHW-1].mask,
                        w_shift_red[SHW]};

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_shifter_pipe
// Brief    : Scoreboard bench driving a PIPELINED=1 and a PIPELINED=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter_pipe;

    localparam int W    = 48;
    localparam int SHW  = 6;
    localparam int LAT1 = SHW;

    typedef struct packed {
        logic         flag;
        logic [W-1:0] data;
    } exp_t;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           iv1       = 1'b0;
    logic           iv0       = 1'b0;
    logic [W-1:0]   in_data   = '0;
    logic [SHW-1:0] in_shift  = '0;
    logic [1:0]     in_mode   = '0;
    logic           out_ready = 1'b1;

    logic           in_ready_p1, out_valid_p1, out_flag_p1;
    logic [W-1:0]   out_data_p1;
    logic           in_ready_p0, out_valid_p0, out_flag_p0;
    logic [W-1:0]   out_data_p0;

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(W), .PIPELINED(1)) dut_p1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(in_ready_p1),
        .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
        .out_valid(out_valid_p1), .out_ready(out_ready),
        .out_data(out_data_p1), .out_flag(out_flag_p1)
    );

    barrel_shifter_pipe #(.WIDTH(W), .PIPELINED(0)) dut_p0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(in_ready_p0),
        .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
        .out_valid(out_valid_p0), .out_ready(out_ready),
        .out_data(out_data_p0), .out_flag(out_flag_p0)
    );

    int     n_assert = 0;
    int     n_fail   = 0;
    exp_t   q1[$];
    exp_t   q0[$];
    exp_t   cur_exp;
    logic   acc1, acc0;
    logic   held1 = 1'b0, held0 = 1'b0;
    logic [W-1:0] hd1, hd0;
    logic   hf1, hf0;
    logic   expect_stall = 1'b0;
    logic   lat_on = 1'b0;
    int     lat_cyc = 0;
    logic   rand_bp = 1'b0;

    // Reference: wide shifts / bit loops; ASR counts only non-sign bits as lost.
    function automatic exp_t model(input logic [W-1:0] d, input logic [SHW-1:0] s,
                                   input logic [1:0] m);
        exp_t         r;
        logic [127:0] w;
        int           amt;
        r   = '0;
        amt = int'(s);
        case (m)
            2'b00: begin
                w      = {80'b0, d} << amt;
                r.data = w[47:0];
                r.flag = |w[127:48];
            end
            2'b01: begin
                w      = {d, 80'b0} >> amt;
                r.data = w[127:80];
                r.flag = |w[79:0];
            end
            2'b10: begin
                for (int j = 0; j < W; j++) begin
                    if (j + amt < W) r.data[j] = d[j+amt];
                    else             r.data[j] = d[W-1];
                end
                for (int j = 0; j < W - 1; j++) begin
                    if (j < amt) r.flag = r.flag | d[j];
                end
            end
            default: begin
                if (amt >= W) amt = amt - W;
                for (int j = 0; j < W; j++) r.data[(j + amt) % W] = d[j];
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: entered just after a falling edge, left at the next one.
    task automatic tick();
        exp_t e;
        #1;
        acc1 = iv1 && in_ready_p1;
        acc0 = iv0 && in_ready_p0;
        if (!reset) begin
            check("in_ready_p1", 64'(in_ready_p1), 64'(!(out_valid_p1 && !out_ready)));
            check("in_ready_p0", 64'(in_ready_p0), 64'(!(out_valid_p0 && !out_ready)));
            if (expect_stall) begin
                check("stall_ready_p1", 64'(in_ready_p1), 64'(0));
                check("stall_ready_p0", 64'(in_ready_p0), 64'(0));
            end
            if (held1) begin
                check("stable_data_p1", 64'(out_data_p1), 64'(hd1));
                check("stable_flag_p1", 64'(out_flag_p1), 64'(hf1));
            end
            if (held0) begin
                check("stable_data_p0", 64'(out_data_p0), 64'(hd0));
                check("stable_flag_p0", 64'(out_flag_p0), 64'(hf0));
            end
            if (out_valid_p1 && out_ready) begin
                if (q1.size() == 0) check("unexpected_p1", 64'(out_valid_p1), 64'(0));
                else begin
                    e = q1.pop_front();
                    check("data_p1", 64'(out_data_p1), 64'(e.data));
                    check("flag_p1", 64'(out_flag_p1), 64'(e.flag));
                end
            end
            if (out_valid_p0 && out_ready) begin
                if (q0.size() == 0) check("unexpected_p0", 64'(out_valid_p0), 64'(0));
                else begin
                    e = q0.pop_front();
                    check("data_p0", 64'(out_data_p0), 64'(e.data));
                    check("flag_p0", 64'(out_flag_p0), 64'(e.flag));
                end
            end
            if (lat_on) begin
                check("lat_p1", 64'(out_valid_p1), 64'((lat_cyc == LAT1) || (lat_cyc == LAT1 + 1)));
                check("lat_p0", 64'(out_valid_p0), 64'((lat_cyc == 1) || (lat_cyc == 2)));
                lat_cyc++;
            end
            if (acc1) q1.push_back(cur_exp);
            if (acc0) q0.push_back(cur_exp);
            held1 = out_valid_p1 && !out_ready;
            hd1   = out_data_p1;
            hf1   = out_flag_p1;
            held0 = out_valid_p0 && !out_ready;
            hd0   = out_data_p0;
            hf0   = out_flag_p0;
        end else begin
            held1 = 1'b0;
            held0 = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [SHW-1:0] s, input logic [1:0] m,
                        input logic use_e, input exp_t e);
        in_data  = d;
        in_shift = s;
        in_mode  = m;
        cur_exp  = use_e ? e : model(d, s, m);
        iv1 = 1'b1;
        iv0 = 1'b1;
        for (int n = 0; n < 64 && (iv1 || iv0); n++) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc1) iv1 = 1'b0;
            if (acc0) iv0 = 1'b0;
        end
        if (iv1 || iv0) begin
            check("accept_timeout_p1", 64'(iv1), 64'(0));
            check("accept_timeout_p0", 64'(iv0), 64'(0));
            iv1 = 1'b0;
            iv0 = 1'b0;
        end
    endtask

    task automatic drain();
        iv1 = 1'b0;
        iv0 = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && (q1.size() + q0.size()) > 0; n++) tick();
        check("drain_p1", 64'(q1.size()), 64'(0));
        check("drain_p0", 64'(q0.size()), 64'(0));
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   vd [11];
        logic [SHW-1:0] vs [11];
        logic [1:0]     vm [11];
        logic [W-1:0]   ve [11];
        logic           vf [11];
        logic [63:0]    r64;
        logic [W-1:0]   bd;
        exp_t           e;

        vd[0]  = 48'h0000_0000_FFFF; vs[0]  = 6'd32; vm[0]  = 2'b00; ve[0]  = 48'hFFFF_0000_0000; vf[0]  = 1'b0;
        vd[1]  = 48'h0000_0000_FFFF; vs[1]  = 6'd40; vm[1]  = 2'b00; ve[1]  = 48'hFF00_0000_0000; vf[1]  = 1'b1;
        vd[2]  = 48'h0000_0000_FFFF; vs[2]  = 6'd63; vm[2]  = 2'b00; ve[2]  = 48'h0;              vf[2]  = 1'b1;
        vd[3]  = 48'h8000_0000_0000; vs[3]  = 6'd47; vm[3]  = 2'b10; ve[3]  = 48'hFFFF_FFFF_FFFF; vf[3]  = 1'b0;
        vd[4]  = 48'h8000_0000_0000; vs[4]  = 6'd63; vm[4]  = 2'b10; ve[4]  = 48'hFFFF_FFFF_FFFF; vf[4]  = 1'b0;
        vd[5]  = 48'h8000_0000_0003; vs[5]  = 6'd1;  vm[5]  = 2'b01; ve[5]  = 48'h4000_0000_0001; vf[5]  = 1'b1;
        vd[6]  = 48'h8000_0000_0003; vs[6]  = 6'd63; vm[6]  = 2'b01; ve[6]  = 48'h0;              vf[6]  = 1'b1;
        vd[7]  = 48'h0000_0000_0001; vs[7]  = 6'd50; vm[7]  = 2'b11; ve[7]  = 48'h0000_0000_0004; vf[7]  = 1'b0;
        vd[8]  = 48'h0000_0000_0001; vs[8]  = 6'd47; vm[8]  = 2'b11; ve[8]  = 48'h8000_0000_0000; vf[8]  = 1'b0;
        vd[9]  = 48'h8123_4567_89AB; vs[9]  = 6'd0;  vm[9]  = 2'b10; ve[9]  = 48'h8123_4567_89AB; vf[9]  = 1'b0;
        vd[10] = 48'hF000_0000_0001; vs[10] = 6'd48; vm[10] = 2'b11; ve[10] = 48'hF000_0000_0001; vf[10] = 1'b0;

        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid_p1", 64'(out_valid_p1), 64'(0));
        check("rst_out_data_p1",  64'(out_data_p1),  64'(0));
        check("rst_out_flag_p1",  64'(out_flag_p1),  64'(0));
        check("rst_in_ready_p1",  64'(in_ready_p1),  64'(1));
        check("rst_out_valid_p0", 64'(out_valid_p0), 64'(0));
        check("rst_out_data_p0",  64'(out_data_p0),  64'(0));
        check("rst_out_flag_p0",  64'(out_flag_p0),  64'(0));
        check("rst_in_ready_p0",  64'(in_ready_p0),  64'(1));

        // Directed vectors with hand-computed expectations, back to back.
        for (int i = 0; i < 11; i++) begin
            e.data = ve[i];
            e.flag = vf[i];
            send(vd[i], vs[i], vm[i], 1'b1, e);
        end
        drain();

        // Random operands with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            r64 = {$urandom(), $urandom()};
            send(r64[W-1:0], SHW'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 1'b0, '0);
        end
        rand_bp = 1'b0;
        drain();

        // 12-beat stream with a 3-cycle stall before beat 8.
        for (int i = 0; i < 12; i++) begin
            bd = 48'h1234_5678_9ABC + W'(i) * 48'h0000_1111_0001;
            if (i == 8) begin
                in_data   = bd;
                in_shift  = SHW'(i * 5);
                in_mode   = 2'(i);
                cur_exp   = model(bd, SHW'(i * 5), 2'(i));
                iv1       = 1'b1;
                iv0       = 1'b1;
                out_ready = 1'b0;
                expect_stall = 1'b1;
                repeat (3) tick();
                expect_stall = 1'b0;
                out_ready = 1'b1;
            end
            send(bd, SHW'(i * 5), 2'(i), 1'b0, '0);
        end
        drain();

        // Two back-to-back beats into an empty pipe: exact latency.
        lat_on  = 1'b1;
        lat_cyc = 0;
        send(48'h0000_0000_00F1, 6'd4, 2'b00, 1'b0, '0);
        send(48'h8000_0000_00F0, 6'd4, 2'b10, 1'b0, '0);
        repeat (7) tick();
        lat_on = 1'b0;
        drain();

        // Reset with four beats in flight; only post-reset beats may emerge.
        for (int i = 0; i < 4; i++) begin
            send(48'hABCD_0000_0000 + W'(i), SHW'(i + 1), 2'b01, 1'b0, '0);
        end
        reset = 1'b1;
        q1.delete();
        q0.delete();
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_valid_p1", 64'(out_valid_p1), 64'(0));
        check("post_rst_valid_p0", 64'(out_valid_p0), 64'(0));
        for (int i = 0; i < 3; i++) begin
            send(48'h0F0F_0F0F_0F0F ^ W'(i), SHW'(7 * i + 3), 2'(3 - i), 1'b0, '0);
        end
        drain();
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
